// File: rtl/quad_encoder_bank.sv
// Multi-channel quadrature encoder front end: 2-flop synchronisers, a shared
// sample tick, per-channel debounce, 1x/4x decode and saturating position.
// Optional illegal-transition flag enabled by defining QUAD_ERR_EN.

module quad_encoder_lane #(
  parameter int DEBOUNCE  = 2,
  parameter int DECODE    = 1,
  parameter int POS_WIDTH = 10,
  parameter int POS_MIN   = 0,
  parameter int POS_MAX   = 1023,
  parameter int POS_INIT  = 512,
  parameter int STEP      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick_i,
  input  logic                 clr_i,
  input  logic                 a_i,
  input  logic                 b_i,
  output logic                 cw_o,
  output logic                 ccw_o,
  output logic                 err_o,
  output logic [POS_WIDTH-1:0] pos_o
);
  localparam logic [POS_WIDTH:0]   STEP_X = (POS_WIDTH+1)'(STEP);
  localparam logic [POS_WIDTH:0]   MIN_X  = (POS_WIDTH+1)'(POS_MIN);
  localparam logic [POS_WIDTH:0]   MAX_X  = (POS_WIDTH+1)'(POS_MAX);
  localparam logic [POS_WIDTH-1:0] STEP_P = POS_WIDTH'(STEP);
  localparam logic [POS_WIDTH-1:0] MIN_P  = POS_WIDTH'(POS_MIN);
  localparam logic [POS_WIDTH-1:0] MAX_P  = POS_WIDTH'(POS_MAX);
  localparam logic [POS_WIDTH-1:0] INIT_P = POS_WIDTH'(POS_INIT);

  logic [1:0] s1_q, s2_q, acc_q, acc_d, last_q, last_d, diff;
  logic [3:0] cnt_q, cnt_d;
  logic       accept, step_cw, step_ccw, cw_q, ccw_q;
  logic [POS_WIDTH-1:0] pos_q, pos_d, dn;
  logic [POS_WIDTH:0]   up;

  // Position of a {A,B} code along the CW Gray sequence 11->01->00->10.
  function automatic logic [1:0] gidx(input logic [1:0] v);
    case (v)
      2'b11:   gidx = 2'd0;
      2'b01:   gidx = 2'd1;
      2'b00:   gidx = 2'd2;
      default: gidx = 2'd3;
    endcase
  endfunction

  // Debounce: a new raw value must be seen on DEBOUNCE consecutive ticks.
  always_comb begin
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    last_d = last_q;
    accept = 1'b0;
    if (tick_i) begin
      last_d = s2_q;
      if (s2_q == acc_q) begin
        cnt_d = 4'd0;
      end else begin
        if (s2_q != last_q) cnt_d = 4'd1;
        else                cnt_d = cnt_q + 4'd1;
        if (cnt_d == 4'(DEBOUNCE)) begin
          acc_d  = s2_q;
          cnt_d  = 4'd0;
          accept = 1'b1;
        end
      end
    end
  end

  // Decode old -> new accepted value into a step direction.
  always_comb begin
    step_cw  = 1'b0;
    step_ccw = 1'b0;
    diff     = gidx(acc_d) - gidx(acc_q);
    if (accept) begin
      if (DECODE == 4) begin
        step_cw  = (diff == 2'd1);
        step_ccw = (diff == 2'd3);
      end else if (acc_q[1] && !acc_d[1] && (acc_q[0] == acc_d[0])) begin
        step_cw  = acc_q[0];
        step_ccw = !acc_q[0];
      end
    end
  end

  // Saturating position; clr wins over a simultaneous step.
  always_comb begin
    up    = {1'b0, pos_q} + STEP_X;
    dn    = pos_q - STEP_P;
    pos_d = pos_q;
    if (clr_i)
      pos_d = INIT_P;
    else if (step_cw)
      pos_d = (up > MAX_X) ? MAX_P : up[POS_WIDTH-1:0];
    else if (step_ccw)
      pos_d = ({1'b0, pos_q} < STEP_X + MIN_X) ? MIN_P : dn;
  end

  // Synchroniser, debounce state, pulses and position registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q   <= 2'b11;
      s2_q   <= 2'b11;
      acc_q  <= 2'b11;
      last_q <= 2'b11;
      cnt_q  <= 4'd0;
      cw_q   <= 1'b0;
      ccw_q  <= 1'b0;
      pos_q  <= INIT_P;
    end else begin
      s1_q   <= {a_i, b_i};
      s2_q   <= s1_q;
      acc_q  <= acc_d;
      last_q <= last_d;
      cnt_q  <= cnt_d;
      cw_q   <= step_cw;
      ccw_q  <= step_ccw;
      pos_q  <= pos_d;
    end
  end

`ifdef QUAD_ERR_EN
  logic err_q;
  // Sticky flag for a double-bit jump; cleared only by clr or reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                   err_q <= 1'b0;
    else if (clr_i)                             err_q <= 1'b0;
    else if (accept && ((acc_q ^ acc_d) == 2'b11)) err_q <= 1'b1;
  end
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign cw_o  = cw_q;
  assign ccw_o = ccw_q;
  assign pos_o = pos_q;
endmodule

module quad_encoder_bank #(
  parameter int CHANNELS   = 2,
  parameter int SAMPLE_DIV = 27000,
  parameter int DEBOUNCE   = 2,
  parameter int DECODE     = 1,
  parameter int POS_WIDTH  = 10,
  parameter int POS_MIN    = 0,
  parameter int POS_MAX    = 1023,
  parameter int POS_INIT   = 512,
  parameter int STEP       = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CHANNELS-1:0]           a,
  input  logic [CHANNELS-1:0]           b,
  input  logic                          clr,
  output logic [CHANNELS-1:0]           cw,
  output logic [CHANNELS-1:0]           ccw,
  output logic [CHANNELS*POS_WIDTH-1:0] pos,
  output logic [CHANNELS-1:0]           err,
  output logic                          tick
);
  localparam int TW = $clog2(SAMPLE_DIV);

  logic [TW-1:0] timer_q, timer_d;
  logic          tick_q;

  assign timer_d = (timer_q == TW'(SAMPLE_DIV-1)) ? '0 : timer_q + 1'b1;

  // Shared sample timer; tick is the registered wrap strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      timer_q <= timer_d;
      tick_q  <= (timer_q == TW'(SAMPLE_DIV-1));
    end
  end

  assign tick = tick_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    quad_encoder_lane #(
      .DEBOUNCE (DEBOUNCE),  .DECODE  (DECODE),  .POS_WIDTH(POS_WIDTH),
      .POS_MIN  (POS_MIN),   .POS_MAX (POS_MAX), .POS_INIT (POS_INIT),
      .STEP     (STEP)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .tick_i(tick_q),
      .clr_i (clr),
      .a_i   (a[g]),
      .b_i   (b[g]),
      .cw_o  (cw[g]),
      .ccw_o (ccw[g]),
      .err_o (err[g]),
      .pos_o (pos[g*POS_WIDTH +: POS_WIDTH])
    );
  end
endmodule
